// File: rtl/reset_sequencer_if.sv
// Control and status bundle of the reset sequencer: restart/clear requests in, reset outputs and status back.
interface reset_sequencer_if #(
    parameter int CHANNELS = 3
);
    logic                sw_reset;
    logic                clear_status;
    logic [CHANNELS-1:0] rst_out;
    logic                ready;
    logic                lock_lost;
    logic [7:0]          lock_loss_count;

    modport master (
        output sw_reset, clear_status,
        input  rst_out, ready, lock_lost, lock_loss_count
    );

    modport slave (
        input  sw_reset, clear_status,
        output rst_out, ready, lock_lost, lock_loss_count
    );
endinterface

// File: rtl/reset_sequencer.sv
// Purpose: holds CHANNELS resets after PLL lock, releases them in index order; lock loss / sw_reset reasserts all.
// Latency: rst_out[0] falls SYNC_STAGES+HOLD_CYCLES edges after reset release; abort lands one edge after lock_s/sw_reset.
// Backpressure: none; outputs are registered. RESET_SEQ_LOSS_COUNT_EN builds the saturating lock-loss counter.
module reset_sequencer #(
    parameter int CHANNELS       = 3,
    parameter int HOLD_CYCLES    = 4194303,
    parameter int STAGGER_CYCLES = 16,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 lock,
    reset_sequencer_if.slave     bus
);
    localparam int MAX_CYC = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
    localparam int CW      = $clog2(MAX_CYC) + 1;
    localparam int IW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [CW-1:0] HOLD_RELOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] STAG_RELOAD = CW'(STAGGER_CYCLES - 1);
    localparam logic [IW-1:0] LAST_IDX    = IW'(CHANNELS - 1);

    typedef enum logic [1:0] {S_HOLD, S_STAGGER, S_RUN} state_t;

    logic [SYNC_STAGES-1:0] rst_sync;
    logic [SYNC_STAGES-1:0] lock_sync;
    logic                   rst_n_int;
    logic                   lock_s;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rst_sync  <= '0;
            lock_sync <= '0;
        end else begin
            rst_sync  <= {rst_sync[SYNC_STAGES-2:0], 1'b1};
            lock_sync <= {lock_sync[SYNC_STAGES-2:0], lock};
        end
    end

    assign rst_n_int = rst_sync[SYNC_STAGES-1];
    assign lock_s    = lock_sync[SYNC_STAGES-1];

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [IW-1:0]       idx;
    logic [CHANNELS-1:0] rst_out_q;
    logic                ready_q;
    logic                lock_lost_q;
    logic                lock_abort;
    logic                abort;

    // Lock dropping inside HOLD only restarts the count; it is not a loss event.
    assign lock_abort = (state != S_HOLD) && !lock_s;
    assign abort      = (state != S_HOLD) && (!lock_s || bus.sw_reset);

    always_ff @(posedge clock or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state       <= S_HOLD;
            cnt         <= HOLD_RELOAD;
            idx         <= '0;
            rst_out_q   <= '1;
            ready_q     <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            if (bus.clear_status)
                lock_lost_q <= 1'b0;
            if (abort) begin
                state     <= S_HOLD;
                cnt       <= HOLD_RELOAD;
                idx       <= '0;
                rst_out_q <= '1;
                ready_q   <= 1'b0;
                if (lock_abort)
                    lock_lost_q <= 1'b1;
            end else begin
                case (state)
                    S_HOLD: begin
                        if (!lock_s || bus.sw_reset) begin
                            cnt <= HOLD_RELOAD;
                        end else if (cnt == '0) begin
                            rst_out_q[0] <= 1'b0;
                            if (CHANNELS == 1) begin
                                state   <= S_RUN;
                                ready_q <= 1'b1;
                            end else begin
                                state <= S_STAGGER;
                                idx   <= IW'(1);
                                cnt   <= STAG_RELOAD;
                            end
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end
                    S_STAGGER: begin
                        if (cnt == '0) begin
                            rst_out_q[idx] <= 1'b0;
                            if (idx == LAST_IDX) begin
                                state   <= S_RUN;
                                ready_q <= 1'b1;
                            end else begin
                                idx <= idx + IW'(1);
                                cnt <= STAG_RELOAD;
                            end
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.rst_out   = rst_out_q;
    assign bus.ready     = ready_q;
    assign bus.lock_lost = lock_lost_q;

`ifdef RESET_SEQ_LOSS_COUNT_EN
    logic [7:0] loss_cnt;

    always_ff @(posedge clock or negedge rst_n_int) begin
        if (!rst_n_int)
            loss_cnt <= '0;
        else if (lock_abort && (loss_cnt != 8'hFF))
            loss_cnt <= loss_cnt + 8'd1;
    end

    assign bus.lock_loss_count = loss_cnt;
`else
    assign bus.lock_loss_count = 8'd0;
`endif
endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer (CHANNELS=3, HOLD=16, STAGGER=4, SYNC=2).
module tb_reset_sequencer;
    logic clock = 1'b0;
    logic reset = 1'b0;
    logic lock  = 1'b0;
    int   edge_no;
    int   checks = 0;
    int   errors = 0;

    reset_sequencer_if #(.CHANNELS(3)) bus ();

    reset_sequencer #(
        .CHANNELS(3), .HOLD_CYCLES(16), .STAGGER_CYCLES(4), .SYNC_STAGES(2)
    ) dut (
        .clock(clock), .reset(reset), .lock(lock), .bus(bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock or negedge reset) begin
        if (!reset) edge_no <= 0;
        else        edge_no <= edge_no + 1;
    end

    typedef struct {
        int         edge_n;
        logic [2:0] rst;
        logic       rdy;
        logic       ll;
        logic [7:0] cnt;
        string      nm;
    } exp_t;

    exp_t exp_q[$];

    function automatic logic [7:0] lc(input int n);
        logic [7:0] v;
        v = (n > 255) ? 8'd255 : 8'(n);
`ifndef RESET_SEQ_LOSS_COUNT_EN
        v = 8'd0;
`endif
        return v;
    endfunction

    task automatic check(input string nm, input logic [2:0] er, input logic erdy,
                         input logic ell, input logic [7:0] ec);
        checks++;
        if ({bus.rst_out, bus.ready, bus.lock_lost, bus.lock_loss_count} !== {er, erdy, ell, ec}) begin
            errors++;
            $display("FAIL %s: got rst_out=%b ready=%b lock_lost=%b count=%0d, expected rst_out=%b ready=%b lock_lost=%b count=%0d",
                     nm, bus.rst_out, bus.ready, bus.lock_lost, bus.lock_loss_count, er, erdy, ell, ec);
        end
    endtask

    task automatic expect_at(input int e, input logic [2:0] r, input logic rdy,
                             input logic ll, input int c, input string nm);
        exp_t x;
        x.edge_n = e; x.rst = r; x.rdy = rdy; x.ll = ll; x.cnt = lc(c); x.nm = nm;
        exp_q.push_back(x);
    endtask

    // Monitor: outputs after edge n are sampled at the following falling edge.
    always @(negedge clock) begin
        if (reset) begin
            while (exp_q.size() > 0 && exp_q[0].edge_n < edge_no) begin
                errors++;
                $display("FAIL %s: expectation for edge %0d never sampled", exp_q[0].nm, exp_q[0].edge_n);
                void'(exp_q.pop_front());
            end
            while (exp_q.size() > 0 && exp_q[0].edge_n == edge_no) begin
                check(exp_q[0].nm, exp_q[0].rst, exp_q[0].rdy, exp_q[0].ll, exp_q[0].cnt);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic at_edge(input int n);
        int guard;
        guard = 0;
        while (edge_no < n) begin
            @(posedge clock);
            #1;
            guard++;
            if (guard > 5000) begin
                $display("FAIL at_edge: edge %0d not reached, at %0d", n, edge_no);
                $fatal(1, "edge wait expired");
            end
        end
    endtask

    task automatic do_reset(input logic lock_init, input string nm);
        reset = 1'b0;
        lock  = lock_init;
        bus.sw_reset     = 1'b0;
        bus.clear_status = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check({nm, "_rst_state"}, 3'b111, 1'b0, 1'b0, 8'd0);
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic drain(input int last, input string nm);
        at_edge(last + 1);
        @(negedge clock);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expectations left unchecked", nm, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        bus.sw_reset     = 1'b0;
        bus.clear_status = 1'b0;

        // Power-up with lock high, then lock loss in RUN and recovery.
        do_reset(1'b1, "pwr");
        expect_at(2,  3'b111, 0, 0, 0, "pwr_e2");
        expect_at(17, 3'b111, 0, 0, 0, "pwr_e17");
        expect_at(18, 3'b110, 0, 0, 0, "pwr_e18");
        expect_at(21, 3'b110, 0, 0, 0, "pwr_e21");
        expect_at(22, 3'b100, 0, 0, 0, "pwr_e22");
        expect_at(25, 3'b100, 0, 0, 0, "pwr_e25");
        expect_at(26, 3'b000, 1, 0, 0, "pwr_e26");
        expect_at(42, 3'b000, 1, 0, 0, "loss_e42");
        expect_at(43, 3'b111, 0, 1, 1, "loss_e43");
        expect_at(67, 3'b111, 0, 1, 1, "relock_e67");
        expect_at(68, 3'b110, 0, 1, 1, "relock_e68");
        expect_at(76, 3'b000, 1, 1, 1, "relock_e76");
        expect_at(80, 3'b000, 1, 1, 1, "clr_e80");
        expect_at(81, 3'b000, 1, 0, 1, "clr_e81");
        at_edge(40); lock = 1'b0;
        at_edge(50); lock = 1'b1;
        at_edge(80); bus.clear_status = 1'b1;
        at_edge(81); bus.clear_status = 1'b0;
        drain(81, "pwr");

        // Lock low at reset release, rising after edge 10.
        do_reset(1'b0, "late");
        expect_at(27, 3'b111, 0, 0, 0, "late_e27");
        expect_at(28, 3'b110, 0, 0, 0, "late_e28");
        expect_at(35, 3'b100, 0, 0, 0, "late_e35");
        expect_at(36, 3'b000, 1, 0, 0, "late_e36");
        at_edge(10); lock = 1'b1;
        drain(36, "late");

        // sw_reset sampled at edge 24 during STAGGER.
        do_reset(1'b1, "sw");
        expect_at(23, 3'b100, 0, 0, 0, "sw_e23");
        expect_at(24, 3'b111, 0, 0, 0, "sw_e24");
        expect_at(39, 3'b111, 0, 0, 0, "sw_e39");
        expect_at(40, 3'b110, 0, 0, 0, "sw_e40");
        expect_at(48, 3'b000, 1, 0, 0, "sw_e48");
        at_edge(23); bus.sw_reset = 1'b1;
        at_edge(24); bus.sw_reset = 1'b0;
        drain(48, "sw");

        // clear_status coinciding with a lock-loss abort at edge 33.
        do_reset(1'b1, "clr");
        expect_at(32, 3'b000, 1, 0, 0, "clr_e32");
        expect_at(33, 3'b111, 0, 1, 1, "clr_set_wins");
        expect_at(40, 3'b111, 0, 1, 1, "clr_e40");
        expect_at(41, 3'b111, 0, 0, 1, "clr_lone");
        at_edge(30); lock = 1'b0;
        at_edge(32); bus.clear_status = 1'b1;
        at_edge(33); bus.clear_status = 1'b0;
        at_edge(40); bus.clear_status = 1'b1;
        at_edge(41); bus.clear_status = 1'b0;
        drain(41, "clr");
`ifdef RESET_SEQ_LOSS_COUNT_EN
        for (int i = 0; i < 300; i++) begin
            lock = 1'b1;
            repeat (24) @(posedge clock);
            #1 lock = 1'b0;
            repeat (5) @(posedge clock);
            #1;
        end
        check("loss_saturate", 3'b111, 1'b0, 1'b1, 8'd255);
`endif

        // Asynchronous reset in the middle of STAGGER.
        do_reset(1'b1, "async");
        expect_at(19, 3'b110, 0, 0, 0, "async_e19");
        at_edge(20);
        #2 reset = 1'b0;
        #1;
        check("async_reset", 3'b111, 1'b0, 1'b0, 8'd0);
        exp_q.delete();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
